ir_nec_decoder: RTL and testbench

IR_NEC_DECODER -- requirements
Module: ir_nec_decoder

---
 rtl/ir_nec_pkg.sv | 42 ++++
 rtl/ir_tick_gen.sv | 21 ++
 rtl/ir_nec_decoder.sv | 142 ++++++++++++++
 tb/tb_ir_nec_decoder.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared NEC decoder types: FSM states, tick-domain timing windows and frame checks.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE, LEAD_L, LEAD_H, BIT_L, BIT_H, STOP
    } ir_state_e;

    localparam int          DUR_W   = 11;
    localparam logic [10:0] DUR_MAX = 11'd2047;

    // Accept windows, in sample ticks (10 us each at the default divider)
    localparam logic [10:0] LEAD_L_MIN = 11'd800;
    localparam logic [10:0] LEAD_L_MAX = 11'd1000;
    localparam logic [10:0] LEAD_H_MIN = 11'd400;
    localparam logic [10:0] LEAD_H_MAX = 11'd500;
    localparam logic [10:0] RPT_H_MIN  = 11'd180;
    localparam logic [10:0] RPT_H_MAX  = 11'd270;
    localparam logic [10:0] BIT_L_MIN  = 11'd40;
    localparam logic [10:0] BIT_L_MAX  = 11'd72;
    localparam logic [10:0] BIT0_MIN   = 11'd40;
    localparam logic [10:0] BIT0_MAX   = 11'd72;
    localparam logic [10:0] BIT1_MIN   = 11'd140;
    localparam logic [10:0] BIT1_MAX   = 11'd200;

    // Abort limits: the longest level each state can legally still be in
    localparam logic [10:0] TMO_LEAD_L = LEAD_L_MAX;
    localparam logic [10:0] TMO_LEAD_H = LEAD_H_MAX;
    localparam logic [10:0] TMO_BIT_L  = BIT_L_MAX;
    localparam logic [10:0] TMO_BIT_H  = BIT1_MAX;
    localparam logic [10:0] TMO_STOP   = BIT_L_MAX;

    function automatic logic in_rng(input logic [10:0] d, input logic [10:0] lo,
                                    input logic [10:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    // Byte layout, LSB first on the wire: addr, ~addr, cmd, ~cmd
    function automatic logic frame_ok(input logic [31:0] f, input logic chk_addr);
        return (f[23:16] == ~f[31:24]) && (!chk_addr || (f[7:0] == ~f[15:8]));
    endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV HCLK cycles.
module ir_tick_gen #(
    parameter int TICK_DIV = 500
) (
    input  logic HCLK,
    input  logic HRESETn,
    output logic tick
);
    localparam int          W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: synchronizes ir_rx, times levels in ticks, and emits
// data / repeat / error pulses one HCLK after the deciding tick.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int TICK_DIV   = 500,
    parameter int CHECK_ADDR = 0
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       ir_rx,
    output logic [7:0] data_out,
    output logic [7:0] addr_out,
    output logic       data_valid,
    output logic       repeat_valid,
    output logic       frame_err,
    output logic       busy
);
    localparam logic CHK_A = (CHECK_ADDR != 0);

    logic        tick;
    logic [1:0]  sync_q;
    logic        rx_s, lvl_q, edg_w;
    logic [10:0] dur_q, cnt_nxt, tmo_w;
    logic        timeout_w;

    ir_state_e   state_q;
    logic [31:0] sr_q;
    logic [4:0]  idx_q;
    logic        rpt_q;
    logic [7:0]  data_q, addr_q;
    logic        dv_q, rv_q, fe_q;

    ir_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .tick    (tick)
    );

    assign rx_s    = sync_q[1];
    assign edg_w   = (rx_s != lvl_q);
    assign cnt_nxt = (dur_q == DUR_MAX) ? DUR_MAX : dur_q + 11'd1;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync_q <= 2'b11;
            lvl_q  <= 1'b1;
            dur_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], ir_rx};
            if (tick) begin
                lvl_q <= rx_s;
                dur_q <= edg_w ? '0 : cnt_nxt;
            end
        end
    end

    always_comb begin
        tmo_w = DUR_MAX;
        case (state_q)
            LEAD_L:  tmo_w = TMO_LEAD_L;
            LEAD_H:  tmo_w = TMO_LEAD_H;
            BIT_L:   tmo_w = TMO_BIT_L;
            BIT_H:   tmo_w = TMO_BIT_H;
            STOP:    tmo_w = TMO_STOP;
            default: tmo_w = DUR_MAX;
        endcase
    end

    // Only states waiting on an edge can time out; IDLE waits forever
    assign timeout_w = tick && !edg_w && (state_q != IDLE) && (cnt_nxt > tmo_w);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            sr_q    <= '0;
            idx_q   <= '0;
            rpt_q   <= 1'b0;
            data_q  <= '0;
            addr_q  <= '0;
            dv_q    <= 1'b0;
            rv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            rv_q <= 1'b0;
            fe_q <= 1'b0;
            if (timeout_w) begin
                state_q <= IDLE;
                fe_q    <= 1'b1;
            end else if (tick && edg_w) begin
                state_q <= IDLE;
                case (state_q)
                    IDLE: if (!rx_s) state_q <= LEAD_L;
                    LEAD_L: begin
                        if (in_rng(cnt_nxt, LEAD_L_MIN, LEAD_L_MAX)) state_q <= LEAD_H;
                        else fe_q <= 1'b1;
                    end
                    LEAD_H: begin
                        if (in_rng(cnt_nxt, LEAD_H_MIN, LEAD_H_MAX)) begin
                            state_q <= BIT_L;
                            idx_q   <= '0;
                            rpt_q   <= 1'b0;
                        end else if (in_rng(cnt_nxt, RPT_H_MIN, RPT_H_MAX)) begin
                            state_q <= STOP;
                            rpt_q   <= 1'b1;
                        end else fe_q <= 1'b1;
                    end
                    BIT_L: begin
                        if (in_rng(cnt_nxt, BIT_L_MIN, BIT_L_MAX)) state_q <= BIT_H;
                        else fe_q <= 1'b1;
                    end
                    BIT_H: begin
                        if (in_rng(cnt_nxt, BIT0_MIN, BIT0_MAX) ||
                            in_rng(cnt_nxt, BIT1_MIN, BIT1_MAX)) begin
                            sr_q    <= {in_rng(cnt_nxt, BIT1_MIN, BIT1_MAX), sr_q[31:1]};
                            idx_q   <= idx_q + 5'd1;
                            state_q <= (idx_q == 5'd31) ? STOP : BIT_L;
                        end else fe_q <= 1'b1;
                    end
                    STOP: begin
                        if (!in_rng(cnt_nxt, BIT_L_MIN, BIT_L_MAX)) fe_q <= 1'b1;
                        else if (rpt_q) rv_q <= 1'b1;
                        else if (frame_ok(sr_q, CHK_A)) begin
                            data_q <= sr_q[23:16];
                            addr_q <= sr_q[7:0];
                            dv_q   <= 1'b1;
                        end else fe_q <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out     = data_q;
    assign addr_out     = addr_q;
    assign data_valid   = dv_q;
    assign repeat_valid = rv_q;
    assign frame_err    = fe_q;
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_ir_nec_decoder.sv
// Scoreboard bench for ir_nec_decoder: directed NEC waveforms, expected pulses queued.
module tb_ir_nec_decoder;
    localparam int TD = 2;

    logic       HCLK = 1'b0;
    logic       HRESETn = 1'b0;
    logic       ir_rx = 1'b1;
    logic [7:0] data_out, addr_out;
    logic       data_valid, repeat_valid, frame_err, busy;

    typedef struct {
        int         kind;   // 0 data_valid, 1 repeat_valid, 2 frame_err
        logic [7:0] d;
        logic [7:0] a;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    ir_nec_decoder #(.TICK_DIV(TD), .CHECK_ADDR(0)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .ir_rx        (ir_rx),
        .data_out     (data_out),
        .addr_out     (addr_out),
        .data_valid   (data_valid),
        .repeat_valid (repeat_valid),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input logic [7:0] a);
        exp_t e;
        e.kind = kind; e.d = d; e.a = a;
        exp_q.push_back(e);
    endtask

    always @(negedge HCLK) begin
        if (HRESETn && (data_valid || repeat_valid || frame_err)) begin
            exp_t e;
            int   k;
            k = data_valid ? 0 : (repeat_valid ? 1 : 2);
            chk("one_pulse", 32'(data_valid) + 32'(repeat_valid) + 32'(frame_err), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'(k), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", 32'(k), 32'(e.kind));
                chk("data_out", {24'd0, data_out}, {24'd0, e.d});
                chk("addr_out", {24'd0, addr_out}, {24'd0, e.a});
            end
        end
    end

    task automatic hold(input logic lvl, input int ticks);
        ir_rx = lvl;
        repeat (ticks * TD) @(negedge HCLK);
    endtask

    task automatic send_bits(input logic [31:0] f, input int nbits, input int bl,
                             input int b0, input int b1);
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, bl);
            hold(1'b1, f[i] ? b1 : b0);
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input int ll, input int lh,
                              input int bl, input int b0, input int b1);
        hold(1'b0, ll);
        hold(1'b1, lh);
        send_bits(f, 32, bl, b0, b1);
        hold(1'b0, bl);
        hold(1'b1, 20);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge HCLK);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge HCLK);
        chk("rst_data", {24'd0, data_out}, 0);
        chk("rst_addr", {24'd0, addr_out}, 0);
        chk("rst_pulses", {29'd0, data_valid, repeat_valid, frame_err}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        HRESETn = 1'b1;
        hold(1'b1, 30);

        // Nominal frame: addr 0x00, cmd 0x45
        push(0, 8'h45, 8'h00);
        send_frame(32'hBA45FF00, 900, 450, 56, 56, 169);
        drain("frame45");
        chk("idle_busy", {31'd0, busy}, 0);

        // Repeat frame leaves outputs alone
        push(1, 8'h45, 8'h00);
        hold(1'b0, 900); hold(1'b1, 225); hold(1'b0, 56); hold(1'b1, 20);
        drain("repeat");

        // Inverted command byte wrong
        push(2, 8'h45, 8'h00);
        send_frame(32'hBB45FF00, 900, 450, 56, 56, 169);
        drain("bad_inv");

        // Bit space of 110 ticks falls between the 0 and 1 windows
        push(2, 8'h45, 8'h00);
        hold(1'b0, 900); hold(1'b1, 450); hold(1'b0, 56); hold(1'b1, 110);
        hold(1'b0, 56); hold(1'b1, 50);
        drain("bit_110");

        // Line stuck low: error only once the leader exceeds 1000 ticks
        push(2, 8'h45, 8'h00);
        hold(1'b0, 995);
        chk("no_early_err", exp_q.size(), 1);
        chk("busy_low_held", {31'd0, busy}, 1);
        hold(1'b0, 205);
        chk("stuck_err", exp_q.size(), 0);
        chk("stuck_idle", {31'd0, busy}, 0);
        hold(1'b1, 20);
        drain("stuck");

        // Reset in the middle of a frame, then a clean frame decodes
        hold(1'b0, 900); hold(1'b1, 450);
        send_bits(32'hE718FF00, 16, 56, 56, 169);
        hold(1'b0, 56); hold(1'b1, 20);
        chk("midframe_busy", {31'd0, busy}, 1);
        HRESETn = 1'b0;
        repeat (5) @(negedge HCLK);
        chk("mid_rst_data", {24'd0, data_out}, 0);
        chk("mid_rst_addr", {24'd0, addr_out}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        HRESETn = 1'b1;
        hold(1'b1, 100);
        chk("post_rst_busy", {31'd0, busy}, 0);
        chk("post_rst_data", {24'd0, data_out}, 0);

        // Minimum edges of every window are accepted
        push(0, 8'h18, 8'h00);
        send_frame(32'hE718FF00, 800, 400, 40, 40, 140);
        drain("frame18");

        chk("final_data", {24'd0, data_out}, 32'h18);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
